timing_capture: RTL and testbench
=================================

Name: timing_capture

Overview:
- Producer side of the timing-statistics path: measures clock-cycle latency from a trigger rising edge to a feedback rising edge.
- Emits each measurement as a value plus a one-cycle catch strobe, which feed directly into the statistics collector's timingIn/fbCatchIn inputs.
- Synchronizes the asynchronous feedback input.
- Supervises each measurement with a timeout and counts successful captures.

Parameters:
- _RAM_WIDTH, 32, width of the latency counter and io_timingOut.
- _TIMEOUT, 1000, maximum captured value before abort; 0 disables timeout.
- _CNT_WIDTH, 16, width of io_catchCnt.

Ports:
- io_clk  input  1  clock.
- io_rst  input  1  reset.
- io_trigIn  input  1  synchronous trigger level; a rising edge starts a measurement.
- io_fbIn  input  1  asynchronous feedback level; a rising edge ends a measurement.
- io_timingOut  output  _RAM_WIDTH  last captured latency in cycles.
- io_fbCatchOut  output  1  one-cycle strobe; io_timingOut is valid in the same cycle.
- io_timeoutOut  output  1  one-cycle strobe when a measurement aborts.
- io_busy  output  1  high while a measurement is running (RUN state).
- io_catchCnt  output  _CNT_WIDTH  number of successful captures, wraps.

Behaviour:
- Reset: io_rst is asynchronous, active-high; clock is io_clk. Reset clears all outputs, io_timingOut, the counter, trigger history and the synchronizer flops to 0, and sets the state to IDLE. Reset mid-measurement aborts silently: no strobes.
- Trigger edge detect: io_trigIn is registered once; trigger edge = current high AND previous sample low.
- Feedback synchronizer: 3-flop chain s1→s2→s3; feedback edge = s2 AND NOT s3.
- FSM states: IDLE, RUN.
- IDLE → RUN on a trigger edge at clock edge T. The counter loads 1 and io_busy goes high after T.
- While in RUN, the counter increments by 1 per cycle and saturates at all-ones (no wrap).
- Feedback edge detected in RUN: at that clock edge the FSM registers io_timingOut = counter, pulses io_fbCatchOut for one cycle, increments io_catchCnt, and returns to IDLE.
  - Let F be the first clock edge at which s1 samples io_fbIn high after a low, with F > T.
  - Capture happens at edge F+2.
  - Captured value = F − T + 2, which includes 2 cycles of synchronizer latency.
- Timeout: if _TIMEOUT ≠ 0 and the counter equals _TIMEOUT with no feedback edge, then at that edge the FSM pulses io_timeoutOut, returns to IDLE, and leaves io_timingOut and io_catchCnt unchanged.
- Feedback edge and timeout in the same cycle: the capture wins and io_timeoutOut stays low.
- Trigger edges while in RUN are ignored; the measurement is not restarted.
- Feedback edges while in IDLE are ignored.
- If io_fbIn is already high at T, a low then a rising transition is required before capture.
- The trigger edge on the same cycle the FSM returns to IDLE is ignored. A new measurement starts on the next trigger edge seen while IDLE, so back-to-back measurements need io_trigIn to fall and rise again.
- io_fbCatchOut and io_timeoutOut are never high simultaneously. Each is high for exactly one cycle per event.

Optional Feature:
- Macro: TIMING_SYNC_COMP_EN.
- When defined, the captured value excludes synchronizer latency: io_timingOut = F − T, via the counter loading −1 (i.e. the counter starts 2 lower). Timeout compares against the uncompensated run length, so abort timing is identical in both builds.
- When undefined, the behaviour is as described above (F − T + 2).

Test Plan:
- Reset: hold io_rst 3 cycles with io_trigIn and io_fbIn toggling → all outputs 0, io_busy 0, no strobes.
- Basic capture: trigger edge at T=10, io_fbIn rises so that F=35 → io_fbCatchOut high one cycle after edge 37, io_timingOut=27 (25 with TIMING_SYNC_COMP_EN), io_catchCnt=1, io_busy low afterwards.
- Timeout: _TIMEOUT=16, trigger with no feedback → io_timeoutOut pulses once, 16 cycles after T. io_timingOut keeps its previous value and io_catchCnt is unchanged. A feedback edge landing on the timeout cycle instead gives io_fbCatchOut with value 16 and no timeout pulse.
- Ignored events: feedback pulse while IDLE → no strobe. Second trigger edge at T+5 during RUN, then F=T+20 → single capture of 22.
- Reset mid-run: assert io_rst at T+8 during RUN → no strobes, io_busy 0. The next trigger at T+20 measures normally from its own edge.
- Saturation: _RAM_WIDTH=8, _TIMEOUT=0, F=T+300 → io_timingOut=255. Then 65536 captures with _CNT_WIDTH=16 → io_catchCnt wraps to 0.

Source files
------------

// File: rtl/timing_capture_if.sv
// Trigger/feedback inputs and measurement results of timing_capture, bundled as one port.
interface timing_capture_if #(
    parameter int _RAM_WIDTH = 32,
    parameter int _CNT_WIDTH = 16
);
    logic                  io_trigIn;
    logic                  io_fbIn;
    logic [_RAM_WIDTH-1:0] io_timingOut;
    logic                  io_fbCatchOut;
    logic                  io_timeoutOut;
    logic                  io_busy;
    logic [_CNT_WIDTH-1:0] io_catchCnt;

    modport master (
        output io_trigIn,
        output io_fbIn,
        input  io_timingOut,
        input  io_fbCatchOut,
        input  io_timeoutOut,
        input  io_busy,
        input  io_catchCnt
    );

    modport slave (
        input  io_trigIn,
        input  io_fbIn,
        output io_timingOut,
        output io_fbCatchOut,
        output io_timeoutOut,
        output io_busy,
        output io_catchCnt
    );
endinterface

// File: rtl/timing_capture.sv
// Measures trigger-rise to feedback-rise latency in io_clk cycles for the statistics collector.
// Define TIMING_SYNC_COMP_EN to remove the 2-cycle synchronizer latency from captured values.
module timing_capture #(
    parameter int _RAM_WIDTH = 32,
    parameter int _TIMEOUT   = 1000,
    parameter int _CNT_WIDTH = 16
) (
    input  logic            io_clk,
    input  logic            io_rst,
    timing_capture_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    // The run length carries one bit above the output width so compensation
    // can subtract from a saturated value without dropping below all-ones.
    localparam int               RUN_W       = _RAM_WIDTH + 1;
    localparam logic [RUN_W-1:0] RUN_MAX     = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] OUT_MAX     = {1'b0, {_RAM_WIDTH{1'b1}}};
    localparam logic [RUN_W-1:0] MIN_RUN     = RUN_W'(3);
    localparam logic [63:0]      TIMEOUT_LIM = 64'(_TIMEOUT);
`ifdef TIMING_SYNC_COMP_EN
    localparam logic [RUN_W-1:0] SYNC_LAT    = RUN_W'(2);
`else
    localparam logic [RUN_W-1:0] SYNC_LAT    = '0;
`endif

    state_t                state;
    state_t                next_state;
    logic                  trig_q;
    logic                  fb_s1;
    logic                  fb_s2;
    logic                  fb_s3;
    logic [RUN_W-1:0]      run_len;
    logic [_RAM_WIDTH-1:0] timing_q;
    logic [_CNT_WIDTH-1:0] catch_cnt;
    logic                  catch_q;
    logic                  timeout_q;

    logic                  trig_edge;
    logic                  fb_edge;
    logic                  timeout_hit;
    logic                  start;
    logic                  capture;
    logic                  abort;
    logic [RUN_W-1:0]      lat;
    logic [_RAM_WIDTH-1:0] lat_sat;

    assign trig_edge   = bus.io_trigIn & ~trig_q;
    assign fb_edge     = fb_s2 & ~fb_s3;
    assign timeout_hit = (_TIMEOUT != 0) && (64'(run_len) == TIMEOUT_LIM);
    assign lat         = run_len - SYNC_LAT;
    assign lat_sat     = (lat > OUT_MAX) ? OUT_MAX[_RAM_WIDTH-1:0] : lat[_RAM_WIDTH-1:0];

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture beats timeout on the same edge. A feedback rise first sampled at
    // or before the trigger edge reaches the edge detector while the run length
    // is still below 3, so it is not taken as the end of this measurement.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    start      = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (fb_edge && (run_len >= MIN_RUN)) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            trig_q    <= 1'b0;
            fb_s1     <= 1'b0;
            fb_s2     <= 1'b0;
            fb_s3     <= 1'b0;
            run_len   <= '0;
            timing_q  <= '0;
            catch_cnt <= '0;
            catch_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            trig_q    <= bus.io_trigIn;
            fb_s1     <= bus.io_fbIn;
            fb_s2     <= fb_s1;
            fb_s3     <= fb_s2;
            catch_q   <= capture;
            timeout_q <= abort;
            if (start) begin
                run_len <= RUN_W'(1);
            end else if ((state == RUN) && (run_len != RUN_MAX)) begin
                run_len <= run_len + RUN_W'(1);
            end
            if (capture) begin
                timing_q  <= lat_sat;
                catch_cnt <= catch_cnt + _CNT_WIDTH'(1);
            end
        end
    end

    assign bus.io_timingOut  = timing_q;
    assign bus.io_fbCatchOut = catch_q;
    assign bus.io_timeoutOut = timeout_q;
    assign bus.io_busy       = (state == RUN);
    assign bus.io_catchCnt   = catch_cnt;

endmodule

// File: tb/tb_timing_capture.sv
// Bench for timing_capture: instance a is the default build, b has a 16-cycle timeout,
// c is 8 bits wide with no timeout and a 4-bit capture counter.
module tb_timing_capture;

`ifdef TIMING_SYNC_COMP_EN
    localparam int COMP = 2;
`else
    localparam int COMP = 0;
`endif
    localparam int TO_B = 16;

    logic io_clk;
    logic io_rst;

    timing_capture_if #(._RAM_WIDTH(32), ._CNT_WIDTH(16)) ia ();
    timing_capture_if #(._RAM_WIDTH(32), ._CNT_WIDTH(16)) ib ();
    timing_capture_if #(._RAM_WIDTH(8),  ._CNT_WIDTH(4))  ic ();

    timing_capture #(._RAM_WIDTH(32), ._TIMEOUT(1000), ._CNT_WIDTH(16)) dut_a (
        .io_clk(io_clk), .io_rst(io_rst), .bus(ia));
    timing_capture #(._RAM_WIDTH(32), ._TIMEOUT(TO_B), ._CNT_WIDTH(16)) dut_b (
        .io_clk(io_clk), .io_rst(io_rst), .bus(ib));
    timing_capture #(._RAM_WIDTH(8), ._TIMEOUT(0), ._CNT_WIDTH(4)) dut_c (
        .io_clk(io_clk), .io_rst(io_rst), .bus(ic));

    int          n_vec = 0;
    int          n_err = 0;
    int          edge_n = 0;
    int          catch_n[3]    = '{0, 0, 0};
    int          to_n[3]       = '{0, 0, 0};
    int          both_n[3]     = '{0, 0, 0};
    int          catch_edge[3] = '{0, 0, 0};
    int          to_edge[3]    = '{0, 0, 0};
    logic [31:0] catch_val[3]  = '{0, 0, 0};
    int          exp_cnt[3]    = '{0, 0, 0};

    initial begin
        io_clk = 1'b0;
        forever #5 io_clk = ~io_clk;
    end

    task automatic set_trig(input int w, input logic v);
        case (w)
            0:       ia.io_trigIn = v;
            1:       ib.io_trigIn = v;
            default: ic.io_trigIn = v;
        endcase
    endtask

    task automatic set_fb(input int w, input logic v);
        case (w)
            0:       ia.io_fbIn = v;
            1:       ib.io_fbIn = v;
            default: ic.io_fbIn = v;
        endcase
    endtask

    task automatic read_outs(input int w, output logic [31:0] tv, output logic cs,
                             output logic ts, output logic bz, output logic [15:0] cnt);
        case (w)
            0: begin
                tv = ia.io_timingOut; cs = ia.io_fbCatchOut; ts = ia.io_timeoutOut;
                bz = ia.io_busy; cnt = ia.io_catchCnt;
            end
            1: begin
                tv = ib.io_timingOut; cs = ib.io_fbCatchOut; ts = ib.io_timeoutOut;
                bz = ib.io_busy; cnt = ib.io_catchCnt;
            end
            default: begin
                tv = 32'(ic.io_timingOut); cs = ic.io_fbCatchOut; ts = ic.io_timeoutOut;
                bz = ic.io_busy; cnt = 16'(ic.io_catchCnt);
            end
        endcase
    endtask

    // Strobe log: every cycle a strobe is seen high is recorded against the edge that raised it.
    task automatic log_dut(input int w);
        logic [31:0] tv;
        logic        cs, ts, bz;
        logic [15:0] cnt;
        read_outs(w, tv, cs, ts, bz, cnt);
        if (cs === 1'b1) begin
            catch_n[w]++;
            catch_edge[w] = edge_n;
            catch_val[w]  = tv;
        end
        if (ts === 1'b1) begin
            to_n[w]++;
            to_edge[w] = edge_n;
        end
        if ((cs === 1'b1) && (ts === 1'b1)) both_n[w]++;
    endtask

    task automatic tick();
        @(posedge io_clk);
        #1;
        edge_n++;
        for (int w = 0; w < 3; w++) log_dut(w);
    endtask

    task automatic wait_until(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic start_meas(input int w, output int t);
        set_trig(w, 1'b1);
        t = edge_n + 1;
    endtask

    task automatic fb_rise_at(input int w, input int f);
        wait_until(f - 1);
        set_fb(w, 1'b1);
    endtask

    task automatic settle(input int w);
        set_trig(w, 1'b0);
        set_fb(w, 1'b0);
        repeat (5) tick();
    endtask

    task automatic do_capture(input int w, input int d, input bit pre_high, output int t);
        if (pre_high) begin
            set_fb(w, 1'b1);
            repeat (4) tick();
        end
        start_meas(w, t);
        if (pre_high) begin
            wait_until(t);
            set_fb(w, 1'b0);
        end
        fb_rise_at(w, t + d);
        wait_until(t + d + 4);
        settle(w);
    endtask

    task automatic test_reset();
        logic [31:0] tv;
        logic        cs, ts, bz;
        logic [15:0] cnt;
        io_rst = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            for (int w = 0; w < 3; w++) begin
                set_trig(w, 1'($urandom_range(0, 1)));
                set_fb(w, 1'($urandom_range(0, 1)));
            end
            tick();
            for (int w = 0; w < 3; w++) begin
                read_outs(w, tv, cs, ts, bz, cnt);
                n_vec++;
                if ({cs, ts, bz} !== 3'b000) begin
                    n_err++;
                    $display("[TB] FAIL reset_flags dut%0d: got %b expected 000", w, {cs, ts, bz});
                end
                n_vec++;
                if ((tv !== 32'd0) || (cnt !== 16'd0)) begin
                    n_err++;
                    $display("[TB] FAIL reset_values dut%0d: got timing %0d cnt %0d expected 0 0", w, tv, cnt);
                end
            end
        end
        for (int w = 0; w < 3; w++) begin
            set_trig(w, 1'b0);
            set_fb(w, 1'b0);
        end
        tick();
        io_rst = 1'b0;
        repeat (3) tick();
        for (int w = 0; w < 3; w++) begin
            read_outs(w, tv, cs, ts, bz, cnt);
            n_vec++;
            if ({cs, ts, bz} !== 3'b000 || tv !== 32'd0 || cnt !== 16'd0) begin
                n_err++;
                $display("[TB] FAIL post_reset dut%0d: got flags %b timing %0d cnt %0d expected all 0",
                         w, {cs, ts, bz}, tv, cnt);
            end
            n_vec++;
            if (catch_n[w] + to_n[w] !== 0) begin
                n_err++;
                $display("[TB] FAIL reset_strobes dut%0d: got %0d strobes expected 0", w, catch_n[w] + to_n[w]);
            end
        end
    endtask

    task automatic test_basic_capture();
        int t, c0;
        c0 = catch_n[0];
        start_meas(0, t);
        wait_until(t);
        n_vec++;
        if (ia.io_busy !== 1'b1) begin
            n_err++; $display("[TB] FAIL basic_busy_on: got %b expected 1", ia.io_busy);
        end
        fb_rise_at(0, t + 25);
        wait_until(t + 26);
        n_vec++;
        if (catch_n[0] !== c0 || ia.io_busy !== 1'b1) begin
            n_err++; $display("[TB] FAIL basic_early: got catches %0d busy %b expected %0d 1", catch_n[0], ia.io_busy, c0);
        end
        wait_until(t + 29);
        exp_cnt[0]++;
        n_vec++;
        if (catch_n[0] !== c0 + 1 || catch_edge[0] !== t + 27) begin
            n_err++; $display("[TB] FAIL basic_strobe: got %0d at edge %0d expected %0d at edge %0d",
                              catch_n[0] - c0, catch_edge[0], 1, t + 27);
        end
        n_vec++;
        if (catch_val[0] !== 32'(27 - COMP)) begin
            n_err++; $display("[TB] FAIL basic_value: got %0d expected %0d", catch_val[0], 27 - COMP);
        end
        n_vec++;
        if (ia.io_catchCnt !== 16'(exp_cnt[0]) || ia.io_busy !== 1'b0 || to_n[0] !== 0) begin
            n_err++; $display("[TB] FAIL basic_state: got cnt %0d busy %b timeouts %0d expected %0d 0 0",
                              ia.io_catchCnt, ia.io_busy, to_n[0], exp_cnt[0]);
        end
        settle(0);
    endtask

    task automatic test_random_capture();
        int t, d, c0;
        bit pre;
        for (int i = 0; i < 8; i++) begin
            d   = int'($urandom_range(1, 80));
            pre = (d >= 2) && ($urandom_range(0, 1) == 1);
            c0  = catch_n[0];
            do_capture(0, d, pre, t);
            exp_cnt[0]++;
            n_vec++;
            if (catch_n[0] !== c0 + 1 || catch_edge[0] !== t + d + 2 || catch_val[0] !== 32'(d + 2 - COMP)) begin
                n_err++; $display("[TB] FAIL random_capture d=%0d pre=%0d: got %0d strobes edge %0d value %0d expected 1 edge %0d value %0d",
                                  d, pre, catch_n[0] - c0, catch_edge[0], catch_val[0], t + d + 2, d + 2 - COMP);
            end
            n_vec++;
            if (ia.io_catchCnt !== 16'(exp_cnt[0])) begin
                n_err++; $display("[TB] FAIL random_count: got %0d expected %0d", ia.io_catchCnt, exp_cnt[0]);
            end
        end
    endtask

    task automatic test_ignored();
        int t, c0;
        c0 = catch_n[0];
        set_fb(0, 1'b1);
        repeat (3) tick();
        set_fb(0, 1'b0);
        repeat (6) tick();
        n_vec++;
        if (catch_n[0] !== c0 || ia.io_busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL idle_feedback: got %0d strobes busy %b expected 0 0", catch_n[0] - c0, ia.io_busy);
        end
        start_meas(0, t);
        wait_until(t + 2);
        set_trig(0, 1'b0);
        wait_until(t + 4);
        set_trig(0, 1'b1);
        fb_rise_at(0, t + 20);
        wait_until(t + 28);
        exp_cnt[0]++;
        n_vec++;
        if (catch_n[0] !== c0 + 1 || catch_edge[0] !== t + 22 || catch_val[0] !== 32'(22 - COMP)) begin
            n_err++; $display("[TB] FAIL retrigger: got %0d strobes edge %0d value %0d expected 1 edge %0d value %0d",
                              catch_n[0] - c0, catch_edge[0], catch_val[0], t + 22, 22 - COMP);
        end
        settle(0);
    endtask

    task automatic test_back_to_back();
        int t, t2, d, d2, c0;
        c0 = catch_n[0];
        d  = int'($urandom_range(3, 30));
        start_meas(0, t);
        wait_until(t + 1);
        set_trig(0, 1'b0);
        fb_rise_at(0, t + d);
        wait_until(t + d + 1);
        set_trig(0, 1'b1);
        wait_until(t + d + 5);
        exp_cnt[0]++;
        n_vec++;
        if (catch_n[0] !== c0 + 1 || catch_val[0] !== 32'(d + 2 - COMP) || ia.io_busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL b2b_first: got %0d strobes value %0d busy %b expected 1 value %0d busy 0",
                              catch_n[0] - c0, catch_val[0], ia.io_busy, d + 2 - COMP);
        end
        set_trig(0, 1'b0);
        set_fb(0, 1'b0);
        repeat (2) tick();
        d2 = int'($urandom_range(1, 30));
        start_meas(0, t2);
        fb_rise_at(0, t2 + d2);
        wait_until(t2 + d2 + 4);
        exp_cnt[0]++;
        n_vec++;
        if (catch_n[0] !== c0 + 2 || catch_edge[0] !== t2 + d2 + 2 || catch_val[0] !== 32'(d2 + 2 - COMP)) begin
            n_err++; $display("[TB] FAIL b2b_second: got %0d strobes edge %0d value %0d expected 2 edge %0d value %0d",
                              catch_n[0] - c0, catch_edge[0], catch_val[0], t2 + d2 + 2, d2 + 2 - COMP);
        end
        n_vec++;
        if (ia.io_catchCnt !== 16'(exp_cnt[0])) begin
            n_err++; $display("[TB] FAIL b2b_count: got %0d expected %0d", ia.io_catchCnt, exp_cnt[0]);
        end
        settle(0);
    endtask

    task automatic test_timeout();
        int t, c0, t0, d, cap_e, to_e;
        int dl[7];
        logic [31:0] last_val;
        do_capture(1, 5, 1'b0, t);
        exp_cnt[1]++;
        last_val = 32'(7 - COMP);
        n_vec++;
        if (catch_val[1] !== last_val) begin
            n_err++; $display("[TB] FAIL timeout_pre_value: got %0d expected %0d", catch_val[1], last_val);
        end
        c0 = catch_n[1];
        t0 = to_n[1];
        start_meas(1, t);
        wait_until(t + TO_B + 8);
        n_vec++;
        if (to_n[1] !== t0 + 1 || to_edge[1] !== t + TO_B) begin
            n_err++; $display("[TB] FAIL timeout_strobe: got %0d at edge %0d expected 1 at edge %0d",
                              to_n[1] - t0, to_edge[1], t + TO_B);
        end
        n_vec++;
        if (catch_n[1] !== c0 || ib.io_timingOut !== last_val || ib.io_catchCnt !== 16'(exp_cnt[1]) || ib.io_busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL timeout_keep: got strobes %0d timing %0d cnt %0d busy %b expected 0 %0d %0d 0",
                              catch_n[1] - c0, ib.io_timingOut, ib.io_catchCnt, ib.io_busy, last_val, exp_cnt[1]);
        end
        settle(1);
        dl[0] = 13; dl[1] = 14; dl[2] = 15;
        for (int i = 3; i < 7; i++) dl[i] = int'($urandom_range(1, 25));
        for (int i = 0; i < 7; i++) begin
            d  = dl[i];
            c0 = catch_n[1];
            t0 = to_n[1];
            start_meas(1, t);
            fb_rise_at(1, t + d);
            cap_e = t + d + 2;
            to_e  = t + TO_B;
            wait_until(((cap_e > to_e) ? cap_e : to_e) + 3);
            if (cap_e <= to_e) begin
                exp_cnt[1]++;
                last_val = 32'(d + 2 - COMP);
                n_vec++;
                if (catch_n[1] !== c0 + 1 || to_n[1] !== t0 || catch_edge[1] !== cap_e) begin
                    n_err++; $display("[TB] FAIL race_capture d=%0d: got catches %0d timeouts %0d edge %0d expected 1 0 edge %0d",
                                      d, catch_n[1] - c0, to_n[1] - t0, catch_edge[1], cap_e);
                end
            end else begin
                n_vec++;
                if (catch_n[1] !== c0 || to_n[1] !== t0 + 1 || to_edge[1] !== to_e) begin
                    n_err++; $display("[TB] FAIL race_timeout d=%0d: got catches %0d timeouts %0d edge %0d expected 0 1 edge %0d",
                                      d, catch_n[1] - c0, to_n[1] - t0, to_edge[1], to_e);
                end
            end
            n_vec++;
            if (ib.io_timingOut !== last_val || ib.io_catchCnt !== 16'(exp_cnt[1])) begin
                n_err++; $display("[TB] FAIL race_outputs d=%0d: got timing %0d cnt %0d expected %0d %0d",
                                  d, ib.io_timingOut, ib.io_catchCnt, last_val, exp_cnt[1]);
            end
            settle(1);
        end
    endtask

    task automatic test_reset_mid_run();
        int t, t2, d, c0, t0;
        c0 = catch_n[0];
        t0 = to_n[0];
        start_meas(0, t);
        wait_until(t + 8);
        io_rst = 1'b1;
        set_trig(0, 1'b0);
        tick();
        for (int w = 0; w < 3; w++) exp_cnt[w] = 0;
        n_vec++;
        if (ia.io_busy !== 1'b0 || ia.io_timingOut !== 32'd0 || ia.io_catchCnt !== 16'd0) begin
            n_err++; $display("[TB] FAIL midrun_reset: got busy %b timing %0d cnt %0d expected 0 0 0",
                              ia.io_busy, ia.io_timingOut, ia.io_catchCnt);
        end
        io_rst = 1'b0;
        wait_until(t + 19);
        n_vec++;
        if (catch_n[0] !== c0 || to_n[0] !== t0 || ia.io_busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL midrun_silent: got catches %0d timeouts %0d busy %b expected 0 0 0",
                              catch_n[0] - c0, to_n[0] - t0, ia.io_busy);
        end
        d = int'($urandom_range(5, 40));
        start_meas(0, t2);
        fb_rise_at(0, t2 + d);
        wait_until(t2 + d + 4);
        exp_cnt[0]++;
        n_vec++;
        if (catch_n[0] !== c0 + 1 || catch_edge[0] !== t2 + d + 2 || catch_val[0] !== 32'(d + 2 - COMP) ||
            ia.io_catchCnt !== 16'(exp_cnt[0])) begin
            n_err++; $display("[TB] FAIL midrun_next: got %0d strobes edge %0d value %0d cnt %0d expected 1 edge %0d value %0d cnt %0d",
                              catch_n[0] - c0, catch_edge[0], catch_val[0], ia.io_catchCnt, t2 + d + 2, d + 2 - COMP, exp_cnt[0]);
        end
        settle(0);
    endtask

    task automatic test_saturation();
        int t, d, e, c0;
        int dl[3];
        dl[0] = 300; dl[1] = 252; dl[2] = int'($urandom_range(1, 100));
        for (int i = 0; i < 3; i++) begin
            d  = dl[i];
            e  = d + 2 - COMP;
            if (e > 255) e = 255;
            c0 = catch_n[2];
            do_capture(2, d, 1'b0, t);
            exp_cnt[2] = (exp_cnt[2] + 1) % 16;
            n_vec++;
            if (catch_n[2] !== c0 + 1 || catch_val[2] !== 32'(e) || to_n[2] !== 0) begin
                n_err++; $display("[TB] FAIL saturation d=%0d: got %0d strobes value %0d timeouts %0d expected 1 value %0d 0",
                                  d, catch_n[2] - c0, catch_val[2], to_n[2], e);
            end
        end
    endtask

    task automatic test_cnt_wrap();
        int t, d;
        for (int i = 0; i < 17; i++) begin
            d = int'($urandom_range(1, 6));
            do_capture(2, d, 1'b0, t);
            exp_cnt[2] = (exp_cnt[2] + 1) % 16;
            n_vec++;
            if (ic.io_catchCnt !== 4'(exp_cnt[2]) || catch_val[2] !== 32'(d + 2 - COMP)) begin
                n_err++; $display("[TB] FAIL cnt_wrap #%0d: got cnt %0d value %0d expected %0d %0d",
                                  i, ic.io_catchCnt, catch_val[2], exp_cnt[2], d + 2 - COMP);
            end
        end
    endtask

    initial begin
        io_rst = 1'b1;
        ia.io_trigIn = 1'b0; ia.io_fbIn = 1'b0;
        ib.io_trigIn = 1'b0; ib.io_fbIn = 1'b0;
        ic.io_trigIn = 1'b0; ic.io_fbIn = 1'b0;
        test_reset();
        test_basic_capture();
        test_random_capture();
        test_ignored();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        test_saturation();
        test_cnt_wrap();
        for (int w = 0; w < 3; w++) begin
            n_vec++;
            if (both_n[w] !== 0) begin
                n_err++; $display("[TB] FAIL exclusive_strobes dut%0d: got %0d overlaps expected 0", w, both_n[w]);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
